// File: rtl/cfg_loader_pkg.sv
// Shared types and defaults for the fabric configuration loader.
// Consumed by cfg_loader and cfg_serializer.
package cfg_loader_pkg;

    localparam int CFG_CONFIG_WIDTH_DEF = 4651;
    localparam int CFG_WORD_WIDTH_DEF   = 8;
    localparam int CFG_MISMATCH_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/cfg_serializer.sv
// Word-to-bit serializer: one holding register feeding one shift register,
// presenting one bit per cycle on o_cfg_in with o_cfg_en as the bit strobe.
module cfg_serializer
    import cfg_loader_pkg::*;
#(
    parameter int WORD_WIDTH = CFG_WORD_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    input  logic                  i_flush,
    input  logic                  i_accept,
    input  logic [WORD_WIDTH-1:0] i_data,
    output logic                  o_hold_vld,
    output logic                  o_present,
    output logic                  o_cfg_in,
    output logic                  o_cfg_en
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    logic [WORD_WIDTH-1:0] r_hold;
    logic                  r_hold_vld;
    logic [WORD_WIDTH-1:0] r_sh;
    logic [CNT_W-1:0]      r_sh_cnt;
    logic                  r_cfg_in;
    logic                  r_cfg_en;

    logic                  w_sh_busy;
    logic                  w_bit;
    logic [WORD_WIDTH-1:0] w_hold_nxt;
    logic                  w_hold_vld_nxt;
    logic [WORD_WIDTH-1:0] w_sh_nxt;
    logic [CNT_W-1:0]      w_sh_cnt_nxt;

    assign w_sh_busy = (r_sh_cnt != '0);
    assign o_present = i_run & (w_sh_busy | r_hold_vld | i_accept);

    // Bit source priority: shift register, then held word, then the word
    // arriving this cycle, so a fresh word starts shifting without a bubble.
    always_comb begin
        w_bit          = r_cfg_in;
        w_hold_nxt     = r_hold;
        w_hold_vld_nxt = r_hold_vld;
        w_sh_nxt       = r_sh;
        w_sh_cnt_nxt   = r_sh_cnt;
        if (i_run) begin
            if (w_sh_busy) begin
                w_bit        = r_sh[0];
                w_sh_nxt     = r_sh >> 1;
                w_sh_cnt_nxt = r_sh_cnt - CNT_W'(1);
                if (i_accept) begin
                    w_hold_nxt     = i_data;
                    w_hold_vld_nxt = 1'b1;
                end
            end else if (r_hold_vld) begin
                w_bit          = r_hold[0];
                w_sh_nxt       = r_hold >> 1;
                w_sh_cnt_nxt   = CNT_W'(WORD_WIDTH - 1);
                w_hold_vld_nxt = 1'b0;
            end else if (i_accept) begin
                w_bit        = i_data[0];
                w_sh_nxt     = i_data >> 1;
                w_sh_cnt_nxt = CNT_W'(WORD_WIDTH - 1);
            end
        end
        if (i_flush) begin
            w_hold_vld_nxt = 1'b0;
            w_sh_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_sh       <= '0;
            r_sh_cnt   <= '0;
            r_cfg_in   <= 1'b0;
            r_cfg_en   <= 1'b0;
        end else begin
            r_hold     <= w_hold_nxt;
            r_hold_vld <= w_hold_vld_nxt;
            r_sh       <= w_sh_nxt;
            r_sh_cnt   <= w_sh_cnt_nxt;
            r_cfg_in   <= w_bit;
            r_cfg_en   <= o_present;
        end
    end

    assign o_hold_vld = r_hold_vld;
    assign o_cfg_in   = r_cfg_in;
    assign o_cfg_en   = r_cfg_en;

endmodule

// File: rtl/cfg_loader.sv
// Fabric configuration loader: streams a CONFIG_WIDTH-bit bitstream into the
// fabric chain; define CFG_LOADER_READBACK_EN to add a readback verify pass.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | shifting the bitstream into the chain
// VERIFY | second pass, comparing chain tail against re-streamed bits
// DONE   | one-cycle completion pulse
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = CFG_CONFIG_WIDTH_DEF,
    parameter int WORD_WIDTH   = CFG_WORD_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [WORD_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      config_in,
    output logic                      config_en,
    input  logic                      config_out,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [CFG_MISMATCH_W-1:0] mismatch_cnt
);

    localparam int BIT_CNT_W  = $clog2(CONFIG_WIDTH + 1);
    localparam int NUM_WORDS  = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int WORD_CNT_W = $clog2(NUM_WORDS + 1);

    cfg_state_t              r_state;
    cfg_state_t              w_state_nxt;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [WORD_CNT_W-1:0]   r_word_cnt;
    logic                    r_error;

    logic w_active;
    logic w_start_ok;
    logic w_abort_ok;
    logic w_run;
    logic w_hold_vld;
    logic w_accept;
    logic w_present;
    logic w_last;
    logic w_flush;
    logic w_err_set;

    assign w_active   = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_abort_ok = w_active && abort;
    assign w_run      = w_active && !abort;
    assign w_last     = w_present && (r_bit_cnt == BIT_CNT_W'(CONFIG_WIDTH - 1));
    assign w_flush    = w_abort_ok || w_last;

    // Word budget stops the next pass's first word being swallowed as surplus.
    assign s_ready  = w_active && !w_hold_vld && (r_word_cnt != WORD_CNT_W'(NUM_WORDS));
    assign w_accept = s_valid && s_ready;

    cfg_serializer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (w_run),
        .i_flush    (w_flush),
        .i_accept   (w_accept),
        .i_data     (s_data),
        .o_hold_vld (w_hold_vld),
        .o_present  (w_present),
        .o_cfg_in   (config_in),
        .o_cfg_en   (config_en)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
`ifdef CFG_LOADER_READBACK_EN
                    w_state_nxt = ST_VERIFY;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
`ifdef CFG_LOADER_READBACK_EN
            ST_VERIFY: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
`endif
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok || w_flush)
                r_bit_cnt <= '0;
            else if (w_present)
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            if (!w_active || w_flush)
                r_word_cnt <= '0;
            else if (w_accept)
                r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
            if (w_start_ok)
                r_error <= 1'b0;
            else if (w_err_set)
                r_error <= 1'b1;
        end
    end

`ifdef CFG_LOADER_READBACK_EN
    logic                      r_chk;
    logic [CFG_MISMATCH_W-1:0] r_mis_cnt;
    logic                      w_mis;

    // r_chk tracks config_en for verify-pass bits; the chain tail is compared
    // against the bit on config_in at the edge that shifts it in.
    assign w_mis = r_chk && (config_out != config_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk     <= 1'b0;
            r_mis_cnt <= '0;
        end else begin
            r_chk <= w_present && (r_state == ST_VERIFY);
            if (w_start_ok)
                r_mis_cnt <= '0;
            else if (w_mis && (r_mis_cnt != {CFG_MISMATCH_W{1'b1}}))
                r_mis_cnt <= r_mis_cnt + CFG_MISMATCH_W'(1);
        end
    end

    assign w_err_set    = w_abort_ok || w_mis;
    assign mismatch_cnt = r_mis_cnt;
`else
    logic w_unused_cfg_out;

    assign w_unused_cfg_out = config_out;
    assign w_err_set        = w_abort_ok;
    assign mismatch_cnt     = '0;
`endif

    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign error = r_error;

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader with a 20-bit bitstream and a modelled
// fabric chain; readback cases compile in with CFG_LOADER_READBACK_EN.
module tb_cfg_loader;

    localparam int CW = 20;
    localparam int WW = 8;
`ifdef CFG_LOADER_READBACK_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic          s_valid = 1'b0;
    logic [WW-1:0] s_data  = '0;
    logic          s_ready;
    logic          config_in;
    logic          config_en;
    logic          config_out;
    logic          busy;
    logic          done;
    logic          error;
    logic [15:0]   mismatch_cnt;

    logic [CW-1:0] chain = '0;

    int n_assert = 0;
    int n_fail   = 0;

    logic        mon_clr = 1'b1;
    int          cap_n;
    int          runs;
    int          gap;
    int          lo_run;
    int          done_n;
    logic [63:0] cap_vec;
    logic        prev_en;

    always #5 clk = ~clk;

    cfg_loader #(
        .CONFIG_WIDTH (CW),
        .WORD_WIDTH   (WW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .config_in    (config_in),
        .config_en    (config_en),
        .config_out   (config_out),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .mismatch_cnt (mismatch_cnt)
    );

    // Fabric chain: config_out is the bit shifted in CW shifts earlier.
    always @(posedge clk) begin
        if (config_en) chain <= {config_in, chain[CW-1:1]};
    end
    assign config_out = chain[0];

    always @(negedge clk) begin
        if (mon_clr) begin
            cap_n   = 0;
            runs    = 0;
            gap     = 0;
            lo_run  = 0;
            done_n  = 0;
            cap_vec = '0;
            prev_en = 1'b0;
        end else begin
            if (config_en) begin
                if (cap_n < 64) cap_vec[cap_n] = config_in;
                if (!prev_en) runs = runs + 1;
                if (cap_n > 0) gap = gap + lo_run;
                lo_run = 0;
                cap_n  = cap_n + 1;
            end else if (cap_n > 0) begin
                lo_run = lo_run + 1;
            end
            if (done) done_n = done_n + 1;
            prev_en = config_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        cyc(1);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] d);
        logic hs;
        hs      = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk);
            #1;
        end
        chk("handshake", 32'(hs), 32'd1);
    endtask

    task automatic send_pass(input logic [WW-1:0] mid);
        send_word(8'hA5);
        send_word(mid);
        send_word(8'h0F);
    endtask

    // Returns just after the negedge on which the n-th shifted bit was seen.
    task automatic wait_bits(input int n);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #1;
            got = (cap_n >= n);
        end
        chk("wait_bits", 32'(got), 32'd1);
    endtask

    initial begin
        // reset state
        cyc(1);
        chk("rst_s_ready",   32'(s_ready),      32'd0);
        chk("rst_cfg_in",    32'(config_in),    32'd0);
        chk("rst_cfg_en",    32'(config_en),    32'd0);
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_done",      32'(done),         32'd0);
        chk("rst_error",     32'(error),        32'd0);
        chk("rst_mismatch",  32'(mismatch_cnt), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // continuous stream A5,3C,0F
        clr_mon();
        pulse_start();
        chk("t1_busy",    32'(busy),    32'd1);
        chk("t1_s_ready", 32'(s_ready), 32'd1);
        send_word(8'hA5);
        chk("t1_first_en", 32'(config_en), 32'd1);
        send_word(8'h3C);
        send_word(8'h0F);
`ifdef CFG_LOADER_READBACK_EN
        send_pass(8'h3C);
`endif
        s_valid = 1'b0;
        cyc(40);
        chk("t1_bits",     32'(cap_n),         32'(CW * NPASS));
        chk("t1_seq",      32'(cap_vec[19:0]), 32'h000F3CA5);
        chk("t1_runs",     32'(runs),          32'd1);
        chk("t1_gap",      32'(gap),           32'd0);
        chk("t1_done",     32'(done_n),        32'd1);
        chk("t1_busy_end", 32'(busy),          32'd0);
        chk("t1_error",    32'(error),         32'd0);
        chk("t1_mismatch", 32'(mismatch_cnt),  32'd0);

        // 5-cycle source stall once the first word has drained
        clr_mon();
        pulse_start();
        send_word(8'hA5);
        s_valid = 1'b0;
        cyc(10);
        chk("t2_stall_en",   32'(config_en), 32'd0);
        chk("t2_stall_hold", 32'(config_in), 32'd1);
        cyc(2);
        send_word(8'h3C);
        send_word(8'h0F);
`ifdef CFG_LOADER_READBACK_EN
        send_pass(8'h3C);
`endif
        s_valid = 1'b0;
        cyc(40);
        chk("t2_bits", 32'(cap_n),         32'(CW * NPASS));
        chk("t2_seq",  32'(cap_vec[19:0]), 32'h000F3CA5);
        chk("t2_runs", 32'(runs),          32'd2);
        chk("t2_gap",  32'(gap),           32'd5);
        chk("t2_done", 32'(done_n),        32'd1);

        // abort at shifted bit 10
        clr_mon();
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        s_valid = 1'b0;
        wait_bits(10);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t3_en_drop", 32'(config_en), 32'd0);
        chk("t3_error",   32'(error),     32'd1);
        chk("t3_done",    32'(done),      32'd0);
        cyc(1);
        chk("t3_busy",    32'(busy),      32'd0);
        chk("t3_s_ready", 32'(s_ready),   32'd0);
        cyc(5);
        chk("t3_bits",    32'(cap_n),     32'd10);
        chk("t3_no_done", 32'(done_n),    32'd0);
        chk("t3_sticky",  32'(error),     32'd1);

        // start pulsed while busy is ignored; new start clears error
        clr_mon();
        pulse_start();
        chk("t4_err_clr", 32'(error), 32'd0);
        send_word(8'hA5);
        start = 1'b1;
        send_word(8'h3C);
        start = 1'b0;
        send_word(8'h0F);
`ifdef CFG_LOADER_READBACK_EN
        send_pass(8'h3C);
`endif
        s_valid = 1'b0;
        cyc(40);
        chk("t4_bits", 32'(cap_n),         32'(CW * NPASS));
        chk("t4_seq",  32'(cap_vec[19:0]), 32'h000F3CA5);
        chk("t4_done", 32'(done_n),        32'd1);

        // abort coinciding with the last load bit
        clr_mon();
        pulse_start();
        send_pass(8'h3C);
        s_valid = 1'b0;
        wait_bits(19);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        cyc(5);
        chk("t5_no_done", 32'(done_n), 32'd0);
        chk("t5_error",   32'(error),  32'd1);
        chk("t5_busy",    32'(busy),   32'd0);

        // asynchronous reset mid-load, then a full reload
        clr_mon();
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        s_valid = 1'b0;
        wait_bits(5);
        rst_n = 1'b0;
        #1;
        chk("t6_cfg_en",   32'(config_en),    32'd0);
        chk("t6_cfg_in",   32'(config_in),    32'd0);
        chk("t6_busy",     32'(busy),         32'd0);
        chk("t6_s_ready",  32'(s_ready),      32'd0);
        chk("t6_done",     32'(done),         32'd0);
        chk("t6_error",    32'(error),        32'd0);
        chk("t6_mismatch", 32'(mismatch_cnt), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        clr_mon();
        pulse_start();
        send_pass(8'h3C);
`ifdef CFG_LOADER_READBACK_EN
        send_pass(8'h3C);
`endif
        s_valid = 1'b0;
        cyc(40);
        chk("t6_bits", 32'(cap_n),         32'(CW * NPASS));
        chk("t6_seq",  32'(cap_vec[19:0]), 32'h000F3CA5);
        chk("t6_done", 32'(done_n),        32'd1);

`ifdef CFG_LOADER_READBACK_EN
        // readback: identical second pass, then one flipped bit (0x3C -> 0x3D)
        clr_mon();
        pulse_start();
        send_pass(8'h3C);
        send_pass(8'h3C);
        s_valid = 1'b0;
        cyc(50);
        chk("rb_ok_mismatch", 32'(mismatch_cnt), 32'd0);
        chk("rb_ok_error",    32'(error),        32'd0);
        chk("rb_ok_done",     32'(done_n),       32'd1);

        clr_mon();
        pulse_start();
        send_pass(8'h3C);
        send_pass(8'h3D);
        s_valid = 1'b0;
        cyc(50);
        chk("rb_bad_mismatch", 32'(mismatch_cnt), 32'd1);
        chk("rb_bad_error",    32'(error),        32'd1);
        chk("rb_bad_done",     32'(done_n),       32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 4651, meaning total bitstream length in bits for a 3x3 mesh.
REQ-002 SHALL have parameter WORD_WIDTH, default 8, meaning host word width in bits.
REQ-003 SHALL have ports, clock and reset first:
- clk  input  1  sole clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse, begins a load when idle.
- abort  input  1  one-cycle pulse, cancels an operation in progress.
- s_data  input  WORD_WIDTH  bitstream word, LSB shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  word accepted when s_valid and s_ready are both high.
- config_in  output  1  serial bit to the fabric chain.
- config_en  output  1  fabric shift enable, one bit per cycle while high.
- config_out  input  1  serial tail of the fabric chain.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse on completion.
- error  output  1  sticky readback mismatch or abort flag.
- mismatch_cnt  output  16  readback mismatch count.

Function
REQ-004 SHALL implement states IDLE, LOAD, VERIFY, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-005 IDLE: start moves to LOAD next cycle and clears error, mismatch_cnt and the bit counter; start is ignored outside IDLE.
REQ-006 SHALL hold one holding register plus one shift register; s_ready = busy AND holding register empty.
REQ-007 config_en SHALL be high exactly on cycles where a valid bit is presented on config_in; no bit is shifted without config_en.
REQ-008 With s_valid held high, bits SHALL shift back-to-back with no idle cycle between words; first config_en one cycle after the first handshake.
REQ-009 SHALL stall shifting (config_en low, config_in held) when the shift register empties and no word is held; shifting resumes the cycle after the next handshake.
REQ-010 Bit counter width SHALL be $clog2(CONFIG_WIDTH+1); a pass ends after exactly CONFIG_WIDTH shifted bits.
REQ-011 Final word: only the remaining (CONFIG_WIDTH mod WORD_WIDTH, or WORD_WIDTH if zero) low bits SHALL shift; upper bits are discarded.
REQ-012 After the last bit of a pass, s_ready SHALL stay low until the next pass begins; a held surplus word is dropped.
REQ-013 Without verify, LOAD completion SHALL go to DONE; busy low the cycle after DONE.
REQ-014 abort in LOAD/VERIFY SHALL drop config_en next cycle, flush both registers, set error and return to IDLE without a done pulse.
REQ-015 abort together with the last bit SHALL take priority: error set, no done.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE and set s_ready, config_in, config_en, busy, done, error to 0 and mismatch_cnt to 0.
REQ-017 Reset mid-shift SHALL discard all buffered bits; the fabric chain then holds a partial bitstream and requires a full reload.

Configuration
REQ-018 Macro CFG_LOADER_READBACK_EN SHALL compile in readback verification.
REQ-019 With it: LOAD completion SHALL go to VERIFY; the host streams the same bitstream again; each shifted bit's config_out SHALL be compared with the bit CONFIG_WIDTH shifts earlier (the corresponding word bit); each mismatch increments mismatch_cnt, saturating at 16'hFFFF, and sets error; VERIFY completion goes to DONE.
REQ-020 Without it: VERIFY SHALL not exist, config_out is unused, mismatch_cnt is tied to 0, and error reports abort only.

Structure
REQ-021 Package cfg_loader_pkg SHALL hold the state enum, default CONFIG_WIDTH and WORD_WIDTH constants, and the mismatch counter width.
REQ-022 Sub-module cfg_serializer SHALL hold the holding register, shift register and per-word bit count; cfg_loader holds the FSM, pass counter and compare logic.

Verification
REQ-023 CONFIG_WIDTH=20, WORD_WIDTH=8, words 0xA5,0x3C,0x0F with s_valid always high -> 20 consecutive config_en cycles, bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1,1,1,1, then a done pulse.
REQ-024 Same stream with s_valid low 5 cycles after the first word -> config_en gap of exactly the stall length, identical 20-bit sequence.
REQ-025 abort at shifted bit 10 -> config_en low next cycle, error=1, no done, busy=0 two cycles later.
REQ-026 Readback enabled, chain modelled as 20-bit shift register, second pass identical -> mismatch_cnt=0, error=0; second pass with 0x3C replaced by 0x3D -> mismatch_cnt=1, error=1.
REQ-027 rst_n asserted mid-LOAD -> all outputs 0 immediately; a following start performs a complete 20-bit load.
REQ-028 start pulsed while busy -> ignored; bit count and output sequence unchanged.
